mac_acc_ctrl: RTL and testbench
===============================

// Module: mac_acc_ctrl
// PURPOSE
//  Accumulator register and sequencing stage wrapped around the 24-bit combinational KSA adder of the MAC.
//  Accepts a stream of 16-bit unsigned products over a valid/ready handshake.
//  Drives the adder operands (acc, zero-extended product) and registers adder sum/cout into the accumulator.
//  Presents the final 24-bit result plus a sticky overflow flag once LEN products have been summed.
// PARAMETERS
//  ACC_W     24  accumulator / adder width (must match adder)
//  PROD_W    16  product width, zero-extended to ACC_W
//  CNT_W     8   width of length field / product counter
//  SATURATE  1   1: clamp acc to all-ones on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  clr        in   1       synchronous abort; highest priority after rst_n
//  start      in   1       begin a run (sampled only in IDLE)
//  len        in   CNT_W   number of products in run, latched on start
//  acc_init   in   ACC_W   accumulator preload value, latched on start
//  prod_valid in   1       product available
//  prod_ready out  1       block accepts product this cycle
//  prod       in   PROD_W  unsigned product
//  add_a      out  ACC_W   adder operand A = acc register
//  add_b      out  ACC_W   adder operand B = {0, prod}
//  add_sum    in   ACC_W   adder sum (combinational return)
//  add_cout   in   1       adder carry-out
//  res_valid  out  1       result available
//  res_ready  in   1       consumer takes result
//  res_data   out  ACC_W   final accumulator value
//  res_ovf    out  1       sticky: any carry-out occurred during run
//  busy       out  1       high in ACC or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, len_q=0, ovf=0; outputs prod_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0.
//  States: IDLE, ACC, DONE. Encoding is free; no other reachable states.
//  IDLE:
//   - start=1 and len!=0: acc<=acc_init, len_q<=len, cnt<=0, ovf<=0, go to ACC.
//   - start=1 and len==0: acc<=acc_init, ovf<=0, go directly to DONE.
//  ACC:
//   - prod_ready=1 combinationally (not dependent on prod_valid).
//   - Accept = prod_valid & prod_ready.
//   - On accept: ovf<=ovf|add_cout; cnt<=cnt+1.
//   - SATURATE=1: acc<=(add_cout|ovf) ? all-ones : add_sum; once saturated, acc holds all-ones for the rest of the run.
//   - SATURATE=0: acc<=add_sum (wraps); ovf remains sticky.
//   - Accept with cnt==len_q-1: go to DONE next edge.
//   - No accept: acc, cnt, ovf unchanged.
//  DONE:
//   - res_valid=1; res_data=acc; res_ovf=ovf; prod_ready=0.
//   - Outputs hold stable until res_ready=1, then go to IDLE next edge.
//   - start is ignored while in DONE.
//  Operands:
//   - add_a/add_b are driven continuously in every state, including IDLE (no gating).
//   - add_b upper ACC_W-PROD_W bits are 0.
//  Latency: res_valid rises on the edge after the last accept. Throughput is 1 product/cycle, with no bubbles.
//  res_data/res_ovf hold their values in IDLE until the next start; they reset to 0 only on rst_n.
//  clr=1 (any state): go to IDLE, cnt<=0, ovf<=0; acc unchanged; clr wins over start and accept in the same cycle.
//  start outside IDLE: ignored, with no effect on len_q or acc.
//  rst_n asserted mid-run: immediate async return to reset state; no partial result is presented.
// TESTING
//  1. acc_init=0, len=3, prods 0x0010,0x0020,0x0030 back-to-back -> res_data=0x000060, res_ovf=0, res_valid 1 cycle after 3rd accept.
//  2. As test 1 with prod_valid deasserted 2 cycles between items -> same result; acc/cnt frozen during gaps.
//  3. SATURATE=1, acc_init=0xFFFFF0, len=2, prods 0x0020,0x0001 -> res_data=0xFFFFFF, res_ovf=1.
//  4. SATURATE=0, same stimulus as test 3 -> res_data=0x000011, res_ovf=1.
//  5. len=0, acc_init=0x123456 -> DONE the cycle after start, res_data=0x123456; hold res_ready=0 for 4 cycles -> outputs stable, then IDLE after res_ready.
//  6. clr asserted after 1 of 3 accepts, and separately rst_n pulsed mid-run -> IDLE, prod_ready=0, no res_valid; a new run of len=1 with prod 0x0005 and acc_init=0 gives 0x000005.

Source files
------------

// File: rtl/mac_acc_ctrl.sv
// mac_acc_ctrl: accumulator and sequencing stage around the external 24-bit KSA adder of the MAC.
module mac_acc_ctrl #(
  parameter int ACC_W    = 24,
  parameter int PROD_W   = 16,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [ACC_W-1:0]  acc_init,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  add_a,
  output logic [ACC_W-1:0]  add_b,
  input  logic [ACC_W-1:0]  add_sum,
  input  logic              add_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, len_q;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic ovf, ovf_nxt, accept;
  assign prod_ready = state == ACC;
  assign res_valid  = state == DONE;
  assign busy       = state != IDLE;
  assign add_a      = acc;
  assign add_b      = {{(ACC_W-PROD_W){1'b0}}, prod};
  assign accept     = prod_valid & prod_ready;
  assign ovf_nxt    = ovf | add_cout;
  // once an overflow has been seen, saturation pins acc at all-ones for the rest of the run
  assign acc_nxt    = (SATURATE && ovf_nxt) ? '1 : add_sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      ovf      <= 1'b0;
      res_data <= '0;
      res_ovf  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= acc_init;
          ovf   <= 1'b0;
          cnt   <= '0;
          len_q <= len;
          if (len == '0) begin
            state    <= DONE;
            res_data <= acc_init;
            res_ovf  <= 1'b0;
          end else state <= ACC;
        end
        ACC: if (accept) begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(len_q - 1'b1)) begin
            state    <= DONE;
            res_data <= acc_nxt;
            res_ovf  <= ovf_nxt;
          end
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_acc_ctrl.sv
// tb_mac_acc_ctrl: directed tests for mac_acc_ctrl, saturating and wrapping instances in lockstep.
module tb_mac_acc_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0, prod_valid = 1'b0, res_ready = 1'b0;
  logic [7:0] len = '0;
  logic [23:0] acc_init = '0;
  logic [15:0] prod = '0;
  logic prdy_s, prdy_w, rv_s, rv_w, ro_s, ro_w, busy_s, busy_w, co_s, co_w;
  logic [23:0] aa_s, aa_w, ab_s, ab_w, sum_s, sum_w, rd_s, rd_w;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign {co_s, sum_s} = {1'b0, aa_s} + {1'b0, ab_s};
  assign {co_w, sum_w} = {1'b0, aa_w} + {1'b0, ab_w};
  mac_acc_ctrl #(.SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len), .acc_init(acc_init),
    .prod_valid(prod_valid), .prod_ready(prdy_s), .prod(prod), .add_a(aa_s), .add_b(ab_s),
    .add_sum(sum_s), .add_cout(co_s), .res_valid(rv_s), .res_ready(res_ready),
    .res_data(rd_s), .res_ovf(ro_s), .busy(busy_s));
  mac_acc_ctrl #(.SATURATE(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len), .acc_init(acc_init),
    .prod_valid(prod_valid), .prod_ready(prdy_w), .prod(prod), .add_a(aa_w), .add_b(ab_w),
    .add_sum(sum_w), .add_cout(co_w), .res_valid(rv_w), .res_ready(res_ready),
    .res_data(rd_w), .res_ovf(ro_w), .busy(busy_w));

  task automatic do_start(input logic [23:0] ai, input logic [7:0] l);
    acc_init = ai; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] p);
    prod_valid = 1'b1; prod = p;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({prdy_s, rv_s, ro_s, busy_s} !== 4'b0 || rd_s !== 24'h0 || aa_s !== 24'h0) begin
      fails++; $display("FAIL reset: rdy/rv/ovf/busy=%b res=%h acc=%h want 0", {prdy_s, rv_s, ro_s, busy_s}, rd_s, aa_s);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_start(24'h0, 8'd3);
    tests++;
    if (prdy_s !== 1'b1 || busy_s !== 1'b1) begin
      fails++; $display("FAIL b2b_acc_state: prod_ready=%b busy=%b want 1 1", prdy_s, busy_s);
    end
    send(16'h0010);
    send(16'h0020);
    prod_valid = 1'b1; prod = 16'h0030;
    #1;
    tests++;
    if (ab_s !== 24'h000030 || rv_s !== 1'b0) begin
      fails++; $display("FAIL b2b_operand: add_b=%h res_valid=%b want 000030 0", ab_s, rv_s);
    end
    @(negedge clk);
    prod_valid = 1'b0;
    tests++;
    if (rv_s !== 1'b1 || rd_s !== 24'h000060 || ro_s !== 1'b0 || prdy_s !== 1'b0) begin
      fails++; $display("FAIL b2b_result: rv=%b res=%h ovf=%b rdy=%b want 1 000060 0 0", rv_s, rd_s, ro_s, prdy_s);
    end
    take_result();
    tests++;
    if (rv_s !== 1'b0 || busy_s !== 1'b0 || rd_s !== 24'h000060) begin
      fails++; $display("FAIL b2b_idle_hold: rv=%b busy=%b res=%h want 0 0 000060", rv_s, busy_s, rd_s);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] p [3] = '{16'h0010, 16'h0020, 16'h0030};
    logic [23:0] a [3] = '{24'h000010, 24'h000030, 24'h000060};
    do_start(24'h0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      send(p[i]);
      if (i < 2) begin
        repeat (2) @(negedge clk);
        tests++;
        if (aa_s !== a[i] || rv_s !== 1'b0 || prdy_s !== 1'b1) begin
          fails++; $display("FAIL gap_freeze%0d: acc=%h rv=%b rdy=%b want %h 0 1", i, aa_s, rv_s, prdy_s, a[i]);
        end
      end
    end
    tests++;
    if (rv_s !== 1'b1 || rd_s !== 24'h000060 || ro_s !== 1'b0) begin
      fails++; $display("FAIL gap_result: rv=%b res=%h ovf=%b want 1 000060 0", rv_s, rd_s, ro_s);
    end
    take_result();
  endtask

  task automatic test_overflow();
    do_start(24'hFFFFF0, 8'd2);
    send(16'h0020);
    tests++;
    if (aa_s !== 24'hFFFFFF || aa_w !== 24'h000010) begin
      fails++; $display("FAIL ovf_mid: sat acc=%h wrap acc=%h want FFFFFF 000010", aa_s, aa_w);
    end
    send(16'h0001);
    tests++;
    if (rv_s !== 1'b1 || rd_s !== 24'hFFFFFF || ro_s !== 1'b1) begin
      fails++; $display("FAIL ovf_saturate: rv=%b res=%h ovf=%b want 1 FFFFFF 1", rv_s, rd_s, ro_s);
    end
    tests++;
    if (rv_w !== 1'b1 || rd_w !== 24'h000011 || ro_w !== 1'b1) begin
      fails++; $display("FAIL ovf_wrap: rv=%b res=%h ovf=%b want 1 000011 1", rv_w, rd_w, ro_w);
    end
    take_result();
  endtask

  task automatic test_zero_len();
    do_start(24'h123456, 8'd0);
    tests++;
    if (rv_s !== 1'b1 || rd_s !== 24'h123456 || ro_s !== 1'b0 || busy_s !== 1'b1 || prdy_s !== 1'b0) begin
      fails++; $display("FAIL zlen_done: rv=%b res=%h ovf=%b busy=%b rdy=%b want 1 123456 0 1 0", rv_s, rd_s, ro_s, busy_s, prdy_s);
    end
    acc_init = 24'h0; len = 8'd5; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (rv_s !== 1'b1 || rd_s !== 24'h123456 || aa_s !== 24'h123456) begin
        fails++; $display("FAIL zlen_hold%0d: rv=%b res=%h acc=%h want 1 123456 123456", i, rv_s, rd_s, aa_s);
      end
    end
    start = 1'b0;
    take_result();
    tests++;
    if (rv_s !== 1'b0 || busy_s !== 1'b0 || rd_s !== 24'h123456) begin
      fails++; $display("FAIL zlen_idle: rv=%b busy=%b res=%h want 0 0 123456", rv_s, busy_s, rd_s);
    end
  endtask

  task automatic short_run(input string tag);
    do_start(24'h0, 8'd1);
    send(16'h0005);
    tests++;
    if (rv_s !== 1'b1 || rd_s !== 24'h000005 || ro_s !== 1'b0) begin
      fails++; $display("FAIL %s_rerun: rv=%b res=%h ovf=%b want 1 000005 0", tag, rv_s, rd_s, ro_s);
    end
    take_result();
  endtask

  task automatic test_abort();
    do_start(24'h0, 8'd3);
    send(16'h0010);
    clr = 1'b1; prod_valid = 1'b1; prod = 16'h0020;
    @(negedge clk);
    clr = 1'b0; prod_valid = 1'b0;
    tests++;
    if (prdy_s !== 1'b0 || rv_s !== 1'b0 || busy_s !== 1'b0 || aa_s !== 24'h000010) begin
      fails++; $display("FAIL clr_abort: rdy=%b rv=%b busy=%b acc=%h want 0 0 0 000010", prdy_s, rv_s, busy_s, aa_s);
    end
    short_run("clr");
    do_start(24'h0, 8'd3);
    send(16'h0010);
    rst_n = 1'b0;
    #1;
    tests++;
    if (prdy_s !== 1'b0 || rv_s !== 1'b0 || busy_s !== 1'b0 || rd_s !== 24'h0 || aa_s !== 24'h0) begin
      fails++; $display("FAIL rst_abort: rdy=%b rv=%b busy=%b res=%h acc=%h want 0 0 0 0 0", prdy_s, rv_s, busy_s, rd_s, aa_s);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    short_run("rst");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_zero_len();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
